// File: rtl/rv_alu_seq.sv
// rv_alu_seq: handshaked integer ALU with a registered result.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
module rv_alu_seq #(
    parameter int WIDTH = 32,
    // Derived from WIDTH; not meant to be overridden.
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    localparam logic [WIDTH-1:0] BAD = WIDTH'(32'hDEAD_BEEF);

    logic [1:0]       state;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;

    assign shamt      = in_b[SHW-1:0];
    assign out_valid  = (state == HOLD);
    assign in_ready   = (state == IDLE) | ((state == HOLD) & out_ready);
    assign accept     = in_valid & in_ready;
    assign out_result = res;
    assign out_zero   = zero;
    assign out_err    = err;

    // Result computed at accept; iterative shifts just load operand A here.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        unique case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(in_a) < $signed(in_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
`else
            OP_SLL, OP_SRL, OP_SRA: alu_res = in_a;
`endif
            default: begin
                alu_res = BAD;
                alu_err = 1'b1;
            end
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN

    // Every op completes at accept, so only IDLE and HOLD are used.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            res   <= '0;
            zero  <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            state <= HOLD;
            res   <= alu_res;
            zero  <= (alu_res == '0);
            err   <= alu_err;
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
        end
    end

`else

    logic [SHW-1:0]   cnt;
    logic [3:0]       sop;
    logic [WIDTH-1:0] step;
    logic             go_shift;

    assign go_shift = (in_op == OP_SLL || in_op == OP_SRL ||
                       in_op == OP_SRA) && (shamt != '0);

    // One-bit shift of the working register for the latched shift op.
    always_comb begin
        case (sop)
            OP_SLL:  step = {res[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, res[WIDTH-1:1]};
            default: step = {res[WIDTH-1], res[WIDTH-1:1]};
        endcase
    end

    // Handshake FSM; res doubles as the shift working register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            res   <= '0;
            zero  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            sop   <= OP_ADD;
        end else if (accept) begin
            res  <= alu_res;
            zero <= (alu_res == '0);
            err  <= alu_err;
            if (go_shift) begin
                state <= SHIFT;
                cnt   <= shamt;
                sop   <= in_op;
            end else begin
                state <= HOLD;
            end
        end else begin
            unique case (state)
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                SHIFT: begin
                    res <= step;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= HOLD;
                        zero  <= (step == '0);
                    end
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_rv_alu_seq.sv
// tb_rv_alu_seq: scoreboard bench for rv_alu_seq.
// Honours ALU_FAST_SHIFT_EN for the expected shift latency.
module tb_rv_alu_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_err;

    int checks   = 0;
    int failures = 0;
    int negcnt   = 0;
    bit seen     = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          due;
    } exp_t;

    exp_t q[$];

    rv_alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V style integer ops on 32-bit values.
    function automatic exp_t model(logic [3:0] op, logic [31:0] a,
                                   logic [31:0] b);
        exp_t e;
        e.err = 1'b0;
        e.due = 0;
        case (op)
            4'd0:    e.res = a + b;
            4'd1:    e.res = a - b;
            4'd2:    e.res = a & b;
            4'd3:    e.res = a | b;
            4'd4:    e.res = a ^ b;
            4'd5:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    e.res = (a < b) ? 32'd1 : 32'd0;
            4'd7:    e.res = a << b[4:0];
            4'd8:    e.res = a >> b[4:0];
            4'd9:    e.res = $signed(a) >>> b[4:0];
            default: begin
                e.res = 32'hDEAD_BEEF;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic int lat_of(logic [3:0] op, logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (op >= 4'd7 && op <= 4'd9) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: checks handshake/results each cycle, pops on handshake,
    // and pushes the model's response for every accepted input.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        negcnt++;
        if (!resetn) begin
            q.delete();
            seen = 0;
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_result", out_result, 32'd0);
            chk("rst_zero", 32'(out_zero), 32'd0);
            chk("rst_err", 32'(out_err), 32'd0);
        end else begin
            if (q.size() == 0)          exp_rdy = 1'b1;
            else if (negcnt < q[0].due) exp_rdy = 1'b0;
            else                        exp_rdy = out_ready;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (out_valid && q.size() == 0)
                chk("spurious_valid", 32'(out_valid), 32'd0);
            if (q.size() > 0 && !seen && (out_valid || negcnt == q[0].due))
            begin
                chk("latency", 32'(negcnt), 32'(q[0].due));
                if (out_valid) seen = 1;
            end
            if (out_valid && q.size() > 0) begin
                chk("result", out_result, q[0].res);
                chk("err", 32'(out_err), 32'(q[0].err));
                chk("zero", 32'(out_zero), 32'(q[0].res == 32'd0));
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_op, in_a, in_b);
                e.due = negcnt + lat_of(in_op, in_b);
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rbp);
        bit ok;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int i = 0; ; i++) begin
            if (i >= 200) begin
                $display("FAIL issue_timeout: op %0d never accepted", op);
                $fatal(1);
            end
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rbp) out_ready = 1'($urandom_range(0, 1));
            if (ok) break;
        end
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; ; i++) begin
            if (q.size() == 0) break;
            if (i >= 200) begin
                $display("FAIL drain_timeout: %0d results pending", q.size());
                $fatal(1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        issue(4'd5, 32'h8000_0000, 32'h0000_0001, 0);
        issue(4'd6, 32'h8000_0000, 32'h0000_0001, 0);
        issue(4'd9, 32'h8000_0010, 32'h0000_0024, 0);
        issue(4'd12, $urandom, $urandom, 0);
        drain();

        out_ready = 1'b0;
        issue(4'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        issue(4'd1, 32'd5, 32'd7, 0);
        drain();

        issue(4'd7, 32'h0000_1234, 32'd20, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(4'd0, 32'd3, 32'd4, 0);
        drain();

        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            issue(op, a, b, 1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_alu_seq.md
# rv_alu_seq

Parametrised, handshaked successor of the core's combinational integer ALU. It adds compare and shift operations, a registered result with valid/ready flow control, and an error flag for illegal opcodes. Shifts are iterative by default, or a single-cycle barrel shifter when configured. It sits between the decode/operand-fetch stage and writeback, and can stall either side.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  input  1  single clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept an operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B; shifts use in_b[SHW-1:0] only
- in_op  input  4  opcode
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts the result
- out_result  output  WIDTH  result
- out_zero  output  1  out_result == 0
- out_err  output  1  opcode was illegal

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a − b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT (signed, result 0/1)
  - 6 SLTU (unsigned, result 0/1)
  - 7 SLL
  - 8 SRL
  - 9 SRA
  - 10–15 illegal
- Arithmetic is modulo 2^WIDTH; carries are discarded.
- Illegal opcode: out_result = 32'hDEAD_BEEF zero-extended or truncated to WIDTH; out_err = 1. Latency is the same as ADD.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE → HOLD on accept of a non-shift op, or of a shift with amount 0.
  - IDLE → SHIFT on accept of a shift with amount > 0. The shift counter loads with the amount; the working register loads with in_a.
  - SHIFT: each cycle, shift the working register by 1 bit (SRA replicates the MSB) and decrement the counter. Go to HOLD in the cycle the counter reaches 0.
  - HOLD: out_valid = 1. On out_ready, go to IDLE, or stay in HOLD if a new non-shift op is accepted in the same cycle. A shift accepted in that cycle goes to SHIFT (or HOLD if its amount is 0).
- in_ready = (state == IDLE) | (state == HOLD & out_ready).
- Inputs are sampled only on in_valid & in_ready. in_a, in_b and in_op may change freely at any other time.
- out_result, out_zero and out_err are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset (asynchronous assert, synchronous-release use): state = IDLE, out_valid = 0, out_result = 0, out_zero = 0, out_err = 0, counter = 0.
- Reset mid-shift or in HOLD discards the operation; no result is produced.
- Non-shift op accepted in cycle N: out_valid = 1 in cycle N+1.
- Back-to-back non-shift ops with out_ready held at 1: one result per cycle.
- Iterative shift with amount s accepted in cycle N: out_valid in cycle N+1+s. Maximum latency is WIDTH cycles (s = WIDTH−1).
- in_ready = 0 throughout SHIFT, and in HOLD while out_ready = 0.

## Configuration
- ALU_FAST_SHIFT_EN defined:
  - All shifts complete combinationally at accept: IDLE → HOLD, latency 1 cycle.
  - SHIFT state and counter are not built.
  - Throughput is 1 op/cycle for all opcodes.
- ALU_FAST_SHIFT_EN undefined: iterative 1-bit-per-cycle shifter as described above.
- Results are bit-identical in both modes; only the latency differs.

## Test plan
- Reset, then ADD 0xFFFF_FFFF + 0x0000_0001 with out_ready = 1:
  - out_valid one cycle after accept
  - out_result = 0x0000_0000, out_zero = 1, out_err = 0
- SLT a = 0x8000_0000, b = 0x0000_0001 → 1.
  - SLTU on the same operands → 0.
  - Back-to-back accepts, results on consecutive cycles.
- SRA a = 0x8000_0010, b = 0x0000_0024 (amount 4):
  - out_result = 0xF800_0001
  - Iterative build: out_valid 5 cycles after accept, in_ready = 0 for the 4 SHIFT cycles
  - ALU_FAST_SHIFT_EN build: out_valid 1 cycle after accept
- in_op = 12, any operands → out_result = 0xDEAD_BEEF, out_err = 1, latency 1 cycle.
- Backpressure:
  - XOR 0xA5A5_A5A5 ^ 0xFFFF_0000 with out_ready = 0 for 3 cycles → out_result holds 0x5A5A_A5A5 and in_ready = 0.
  - Raise out_ready together with a new SUB 5 − 7 → next result 0xFFFF_FFFE in the following cycle.
- Deassert resetn during an SLL with amount 20 in SHIFT:
  - out_valid = 0 and out_result = 0 immediately
  - After release: no stale result appears, and the first new op completes normally.
